// File: rtl/wrr4_sched_pkg.sv
// Shared types and constants for the wrr4_sched weighted round-robin scheduler.
// Holds the FSM encoding, reset weight, empty select value and one-hot helpers.
package wrr4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int         WEIGHT_RST = 1;
  localparam logic [3:0] SEL_NONE   = 4'b0000;
  localparam logic [3:0] PTR_RST    = 4'b0001;

  // Index of the set bit of a one-hot vector; 0 when the vector is empty.
  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/wrr4_sched_if.sv
// Handshake bundle between wrr4_sched and the 4:1 AXI Stream mux it steers.
// The slave modport is the scheduler's view; master is the mux/environment view.
interface wrr4_sched_if;
  logic [3:0] req;
  logic       mon_TVALID;
  logic       mon_TREADY;
  logic       mon_TLAST;
  logic [3:0] sel;
  logic       busy;

  modport slave (
    input  req,
    input  mon_TVALID,
    input  mon_TREADY,
    input  mon_TLAST,
    output sel,
    output busy
  );

  modport master (
    output req,
    output mon_TVALID,
    output mon_TREADY,
    output mon_TLAST,
    input  sel,
    input  busy
  );
endinterface

// File: rtl/wrr4_sched_rr_pick4.sv
// Combinational round-robin picker: first eligible bit at or after one-hot ptr, wrapping 3->0.
// Uses the doubled-vector subtract trick so no priority chain is needed.
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [3:0] ptr,
  output logic [3:0] pick
);

  logic [7:0] dbl;
  logic [7:0] dbl_pick;

  always_comb begin
    dbl      = {eligible, eligible};
    dbl_pick = dbl & ~(dbl - {4'b0000, ptr});
    pick     = dbl_pick[7:4] | dbl_pick[3:0];
  end

endmodule

// File: rtl/wrr4_sched.sv
// Weighted round-robin grant scheduler for a 4-input AXI Stream mux (whole packets per turn).
// Optional per-input packet counters are built when WRR4_SCHED_STATS_EN is defined.
module wrr4_sched
  import wrr4_pkg::*;
#(
  parameter int CNT_WIDTH  = 4
`ifdef WRR4_SCHED_STATS_EN
  ,
  parameter int STAT_WIDTH = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [1:0]            cfg_idx,
  input  logic [CNT_WIDTH-1:0]  cfg_weight,
`ifdef WRR4_SCHED_STATS_EN
  input  logic [1:0]            stat_idx,
  output logic [STAT_WIDTH-1:0] stat_cnt,
`endif
  wrr4_sched_if.slave           bus
);

  state_t               state, state_nxt;
  logic [3:0]           sel_q, sel_nxt;
  logic [3:0]           ptr, ptr_nxt;
  logic [CNT_WIDTH-1:0] budget, budget_nxt;
  logic                 in_pkt, in_pkt_nxt;
  logic [CNT_WIDTH-1:0] weight [4];

  logic [3:0]           eligible;
  logic [3:0]           pick;
  logic                 flit;
  logic                 tlast_flit;
  logic                 req_g;
  logic                 weight_g_zero;
  logic                 release_now;

  assign flit          = bus.mon_TVALID & bus.mon_TREADY;
  assign tlast_flit    = flit & bus.mon_TLAST;
  assign req_g         = |(bus.req & sel_q);
  assign weight_g_zero = (weight[oh_idx(sel_q)] == '0);

  always_comb begin
    eligible = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = bus.req[i] & (weight[i] != '0);
    end
  end

  rr_pick4 u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .pick     (pick)
  );

  // Weights: a write lands at the edge, so a same-cycle grant load still sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) weight[i] <= CNT_WIDTH'(WEIGHT_RST);
    end else if (cfg_wr) begin
      weight[cfg_idx] <= cfg_weight;
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel_q;
    ptr_nxt     = ptr;
    budget_nxt  = budget;
    in_pkt_nxt  = in_pkt;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        sel_nxt = SEL_NONE;
        if (pick != SEL_NONE) begin
          sel_nxt    = pick;
          budget_nxt = weight[oh_idx(pick)];
          in_pkt_nxt = 1'b0;
          state_nxt  = GRANT;
        end
      end
      GRANT: begin
        if (flit && !bus.mon_TLAST) in_pkt_nxt = 1'b1;
        if (tlast_flit) begin
          in_pkt_nxt = 1'b0;
          budget_nxt = budget - CNT_WIDTH'(1);
          if (budget == CNT_WIDTH'(1)) release_now = 1'b1;
        end
        // Only release early at a packet boundary; a stalled packet keeps its grant.
        if (!in_pkt && !flit && (!req_g || weight_g_zero)) release_now = 1'b1;
        if (release_now) begin
          state_nxt = IDLE;
          sel_nxt   = SEL_NONE;
          ptr_nxt   = rotl1(sel_q);
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = SEL_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= SEL_NONE;
      ptr    <= PTR_RST;
      budget <= '0;
      in_pkt <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_nxt;
      ptr    <= ptr_nxt;
      budget <= budget_nxt;
      in_pkt <= in_pkt_nxt;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.busy = (state == GRANT);

`ifdef WRR4_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
    end else if (state == GRANT && tlast_flit) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) stat_q[i] <= stat_q[i] + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_cnt = stat_q[stat_idx];
`endif

endmodule

// File: tb/tb_wrr4_sched.sv
// Directed bench for wrr4_sched: table of per-cycle vectors plus hand-written corner sequences.
// Stats checks are compiled only when WRR4_SCHED_STATS_EN is defined.
module tb_wrr4_sched;

  logic       clk;
  logic       rst;
  logic       cfg_wr;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_weight;
`ifdef WRR4_SCHED_STATS_EN
  logic [1:0]  stat_idx;
  logic [15:0] stat_cnt;
`endif

  wrr4_sched_if bus ();

  wrr4_sched dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_idx    (cfg_idx),
    .cfg_weight (cfg_weight),
`ifdef WRR4_SCHED_STATS_EN
    .stat_idx   (stat_idx),
    .stat_cnt   (stat_cnt),
`endif
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [2:0] vrl;
    logic       cw;
    logic [1:0] ci;
    logic [3:0] cwt;
    logic [3:0] exp_sel;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input logic r, input logic [3:0] q, input logic [2:0] vrl,
                              input logic cw, input logic [1:0] ci, input logic [3:0] cwt,
                              input logic [3:0] es);
    vec_t v;
    v.rst = r; v.req = q; v.vrl = vrl; v.cw = cw; v.ci = ci; v.cwt = cwt; v.exp_sel = es;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic [2:0] vrl);
    rst            = r;
    bus.req        = q;
    bus.mon_TVALID = vrl[2];
    bus.mon_TREADY = vrl[1];
    bus.mon_TLAST  = vrl[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sel(input string nm, input logic [3:0] es);
    chk({nm, ".sel"}, {28'd0, bus.sel}, {28'd0, es});
    chk({nm, ".busy"}, {31'd0, bus.busy}, {31'd0, (es != 4'b0000)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] s1 [9];
    logic [3:0] s2 [6];
    s1 = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    s2 = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000};

    drive(1'b1, 4'b0000, 3'b000);
    cfg_wr = 1'b0; cfg_idx = 2'd0; cfg_weight = 4'd0;
`ifdef WRR4_SCHED_STATS_EN
    stat_idx = 2'd0;
`endif

    // equal weights, everyone requesting, 1-flit packets
    add(1, 4'hF, 3'b111, 0, 0, 0, 4'b0000);
    for (int i = 0; i < 9; i++) add(0, 4'hF, 3'b111, 0, 0, 0, s1[i]);
    // weighted: input 0 gets 3 packets per turn, input 2 gets 1
    add(1, 4'h0, 3'b000, 0, 0, 0, 4'b0000);
    add(0, 4'h0, 3'b000, 1, 0, 3, 4'b0000);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 6; i++) add(0, 4'b0101, 3'b111, 0, 0, 0, s2[i]);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].req, tbl[k].vrl);
      cfg_wr = tbl[k].cw; cfg_idx = tbl[k].ci; cfg_weight = tbl[k].cwt;
      tick();
      chk_sel($sformatf("vec%0d", k), tbl[k].exp_sel);
    end

`ifdef WRR4_SCHED_STATS_EN
    stat_idx = 2'd0; #1;
    chk("stat0", {16'd0, stat_cnt}, 32'd9);
    stat_idx = 2'd1; #1;
    chk("stat1", {16'd0, stat_cnt}, 32'd0);
    stat_idx = 2'd2; #1;
    chk("stat2", {16'd0, stat_cnt}, 32'd3);
`endif

    // input 1, weight 2: 4-flit packet with a mid-packet stall, req drops after TLAST
    drive(1, 4'h0, 3'b000); cfg_wr = 0; tick();
    drive(0, 4'h0, 3'b000); cfg_wr = 1; cfg_idx = 2'd1; cfg_weight = 4'd2; tick();
    cfg_wr = 0;
    drive(0, 4'b0010, 3'b000); tick(); chk_sel("st.grant", 4'b0010);
    drive(0, 4'b0010, 3'b110); tick(); chk_sel("st.f1", 4'b0010);
    drive(0, 4'b0010, 3'b110); tick(); chk_sel("st.f2", 4'b0010);
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b0010, 3'b100); tick(); chk_sel($sformatf("st.stall%0d", i), 4'b0010);
    end
    for (int i = 3; i < 5; i++) begin
      drive(0, 4'b0000, 3'b000); tick(); chk_sel($sformatf("st.stall%0d", i), 4'b0010);
    end
    drive(0, 4'b0010, 3'b110); tick(); chk_sel("st.f3", 4'b0010);
    drive(0, 4'b0010, 3'b111); tick(); chk_sel("st.f4last", 4'b0010);
    drive(0, 4'b0000, 3'b000); tick(); chk_sel("st.release", 4'b0000);
    drive(0, 4'hF, 3'b000); tick(); chk_sel("st.nextptr", 4'b0100);

    // weight 0 blocks forever; enabling it grants two cycles after the write
    drive(1, 4'h0, 3'b000); tick();
    drive(0, 4'h0, 3'b000); cfg_wr = 1; cfg_idx = 2'd3; cfg_weight = 4'd0; tick();
    cfg_wr = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 4'b1000, 3'b000); tick(); chk_sel($sformatf("w0.blocked%0d", i), 4'b0000);
    end
    cfg_wr = 1; cfg_idx = 2'd3; cfg_weight = 4'd2; tick(); chk_sel("w0.wr", 4'b0000);
    cfg_wr = 0; tick(); chk_sel("w0.grant", 4'b1000);

    // same-cycle write and grant load to input 0: budget uses old weight 1
    drive(1, 4'h0, 3'b000); tick();
    drive(0, 4'b0001, 3'b000); cfg_wr = 1; cfg_idx = 2'd0; cfg_weight = 4'd3; tick();
    chk_sel("wl.grant", 4'b0001);
    cfg_wr = 0;
    drive(0, 4'b0001, 3'b111); tick(); chk_sel("wl.oldbudget", 4'b0000);

    // reset in the middle of a packet
    drive(1, 4'h0, 3'b000); tick();
    drive(0, 4'b0100, 3'b000); tick(); chk_sel("rm.grant", 4'b0100);
    drive(0, 4'b0100, 3'b110); tick(); chk_sel("rm.mid", 4'b0100);
    drive(1, 4'hF, 3'b110); tick(); chk_sel("rm.reset", 4'b0000);
`ifdef WRR4_SCHED_STATS_EN
    stat_idx = 2'd0; #1;
    chk("rm.stat0", {16'd0, stat_cnt}, 32'd0);
`endif
    drive(0, 4'hF, 3'b000); tick(); chk_sel("rm.ptr0", 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wrr4_sched.md
# wrr4_sched

Weighted round-robin grant scheduler for a four-input AXI Stream multiplexer. Drives the one-hot select of a 4:1 mux and watches the mux output handshake. Grants each input a configurable number of whole packets per turn. Sits beside the mux and the optional output pipeline stage and replaces the fixed one-packet-per-turn arbitration where inputs need unequal bandwidth.

## Interface
- CNT_WIDTH, 4, width of per-input weight and budget counter (max weight 2^CNT_WIDTH-1)
- STAT_WIDTH, 16, width of per-input packet counters (only with WRR4_SCHED_STATS_EN)
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  4  TVALID of s3..s0 (bit i = input i)
- mon_TVALID  in  1  mux output TVALID
- mon_TREADY  in  1  mux output TREADY
- mon_TLAST  in  1  mux output TLAST
- cfg_wr  in  1  weight write strobe
- cfg_idx  in  2  input index for cfg_wr
- cfg_weight  in  CNT_WIDTH  packets per turn; 0 disables the input
- sel  out  4  registered one-hot mux select; 0000 = no input connected
- busy  out  1  high in GRANT
- stat_idx  in  2  counter read index (macro only)
- stat_cnt  out  STAT_WIDTH  packets completed by input stat_idx (macro only)

## Operation
- Flit = mon_TVALID & mon_TREADY. Packet ends on a flit with mon_TLAST.
- Registers: weight[0..3] (reset 1), ptr one-hot (reset 0001), budget, in_pkt (reset 0), state (reset IDLE).
- eligible = req & {weight[i]!=0}.
- IDLE: sel=0000. Pick the first eligible bit at or after ptr, wrapping 3->0. If one exists, latch it into sel, load budget=weight[pick], go GRANT. Otherwise stay.
- GRANT, checked every cycle:
  - Flit without TLAST: in_pkt<=1.
  - Flit with TLAST: in_pkt<=0, budget<=budget-1.
  - If budget==1, release.
  - Boundary release: in_pkt==0, no flit this cycle, and either req[g]==0 or weight[g]==0. A mid-packet stall never releases.
- Release: state<=IDLE, sel<=0000, ptr<=rotl(sel,1).
- cfg_wr updates weight[cfg_idx] at the clock edge. A budget already loaded is unaffected. If a write and a grant load to the same index happen in one cycle, the load uses the old weight.
- All eligible inputs with weight 0 blocked: block stays in IDLE forever with no error.

## Timing
- Reset values: sel=0000, busy=0, stat_cnt=0.
- rst mid-packet: returns to IDLE on the next edge. The partial packet is abandoned upstream; no recovery is attempted.
- Grant latency: req rising in IDLE -> sel valid the next cycle. The first flit can pass in that same cycle.
- Final TLAST flit of a turn -> sel=0000 the next cycle. This gives one bubble cycle per turn change.
- Back-to-back packets within a turn have no bubble.
- sel is purely registered, with no combinational path from req or mon_* to sel.

## Configuration
- WRR4_SCHED_STATS_EN defined: four STAT_WIDTH packet counters. Counter g increments on each TLAST flit while granted to g, wraps at 2^STAT_WIDTH, and clears on rst. stat_cnt = counter[stat_idx], combinational read.
- WRR4_SCHED_STATS_EN undefined: counters, stat_idx and stat_cnt are absent.

## Structure
- Package wrr4_pkg holds:
  - State encodings IDLE and GRANT.
  - Weight reset value 1.
  - Select value SEL_NONE=0000.
- Sub-module rr_pick4 is combinational. Inputs are eligible[3:0] and ptr[3:0]; output is one-hot pick[3:0]. It uses the doubled-vector subtract method (pick = dbl & ~(dbl-ptr), then fold the halves).
- FSM, budget and counters live in wrr4_sched.

## Test plan
- Reset, all weights 1, req=1111, each input sends 1-flit packets with mon_TREADY=1 -> sel sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- weight[0]=3, weight[2]=1, req=0101, 1-flit packets -> input 0 passes 3 packets, bubble, input 2 passes 1, repeating.
- Grant to input 1 with weight 2; 4-flit packet with mon_TREADY low 5 cycles mid-packet, then req[1] drops after the first TLAST -> no release during the stall; release the cycle after TLAST; sel=0000 next cycle.
- weight[3]=0, req=1000 -> sel stays 0000, busy=0. Then write weight[3]=2 -> sel=1000 two cycles after cfg_wr.
- rst asserted mid-packet in GRANT -> next cycle sel=0000, busy=0, ptr=0001. With req=1111, the next grant is input 0.
- With WRR4_SCHED_STATS_EN, after the weighted scenario runs 12 packets (9 from input 0, 3 from input 2) -> stat_cnt for index 0 is 9 and for index 2 is 3.
